mod5_serial_tx: RTL and testbench

Serial transmitter for the MOD-5 bitstream checker. Accepts a W-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per accepted serial cycle. It tracks the running remainder mod 5 of the transmitted prefix and, at end of frame, reports the remainder the downstream checker must reach. The block sits upstream of the serial divisibility checker as its stimulus source and golden reference.

---
 rtl/mod5_pkg.sv | 21 ++
 rtl/mod5_rem_tracker.sv | 18 +
 rtl/mod5_serial_tx.sv | 82 ++++++++
 tb/tb_mod5_serial_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod5_pkg.sv
// Shared definitions for the MOD-5 serial transmitter and its downstream checker.
package mod5_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned REM_W = 3;

  // Running remainder step: (2*rem + bit) mod 5; 2*rem+bit <= 9 so one subtract suffices.
  function automatic logic [REM_W-1:0] mod5_next(input logic [REM_W-1:0] rem,
                                                 input logic             data_bit);
    logic [3:0] t;
    t = {rem, 1'b0} + {3'b000, data_bit};
    if (t >= 4'd5) t = t - 4'd5;
    return t[REM_W-1:0];
  endfunction

endpackage

// File: rtl/mod5_rem_tracker.sv
// Remainder-mod-5 accumulator over an MSB-first bitstream.
module mod5_rem_tracker
  import mod5_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             data_bit,
  output logic [REM_W-1:0] rem
);

  always_ff @(posedge clk) begin
    if (reset || clr) rem <= '0;
    else if (en)      rem <= mod5_next(rem, data_bit);
  end

endmodule

// File: rtl/mod5_serial_tx.sv
// MSB-first serial transmitter that reports the word's remainder mod 5 at end of frame.
module mod5_serial_tx
  import mod5_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic [REM_W-1:0] rem_out,
  output logic             rem_valid,
  output logic             div5
);

  localparam int unsigned      CNT_W    = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic [REM_W-1:0] rem;
  logic             accept;
  logic             consume;

  assign accept  = (state == IDLE) && in_valid;
  assign consume = (state == SHIFT) && ser_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            cnt   <= CNT_FULL;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_en) begin
            shreg <= shreg << 1;
            cnt   <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mod5_rem_tracker u_rem (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .en       (consume),
    .data_bit (shreg[W-1]),
    .rem      (rem)
  );

  // Outputs decode registered state only; nothing flows through from inputs.
  assign in_ready  = (state == IDLE);
  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid && shreg[W-1];
  assign ser_first = ser_valid && (cnt == CNT_FULL);
  assign ser_last  = ser_valid && (cnt == CNT_ONE);
  assign rem_valid = (state == DONE);
  assign rem_out   = rem;
  assign div5      = rem_valid && (rem == '0);

endmodule

// File: tb/tb_mod5_serial_tx.sv
// Directed bench for mod5_serial_tx: vector table plus stall, reset, busy and W=1 sequences.
module tb_mod5_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, in_ready, ser_en, ser_out, ser_valid, ser_first, ser_last;
  logic [2:0] rem_out;
  logic       rem_valid, div5;

  logic [0:0] in_data1;
  logic       in_valid1, in_ready1, ser_en1, ser_out1, ser_valid1, ser_first1, ser_last1;
  logic [2:0] rem_out1;
  logic       rem_valid1, div5_1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mod5_serial_tx #(.W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_en(ser_en), .ser_out(ser_out), .ser_valid(ser_valid), .ser_first(ser_first),
    .ser_last(ser_last), .rem_out(rem_out), .rem_valid(rem_valid), .div5(div5)
  );

  mod5_serial_tx #(.W(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .ser_en(ser_en1), .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_first(ser_first1),
    .ser_last(ser_last1), .rem_out(rem_out1), .rem_valid(rem_valid1), .div5(div5_1)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] rem;
    logic       dv;
    int         stall_after;
    int         stall_len;
    int         busy_at;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Send one word on the W=8 instance, checking every serial bit; returns the reported result.
  task automatic run_frame(input logic [7:0] d, input int stall_after, input int stall_len,
                           input int busy_at, output logic [2:0] r, output logic dv);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("idle_ready", in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    ser_en   = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    for (int k = 1; k <= 8; k++) begin
      chk("bit_valid", ser_valid, 1);
      chk("bit_value", ser_out, d[8-k]);
      chk("bit_first", ser_first, k == 1);
      chk("bit_last", ser_last, k == 8);
      chk("busy_ready", in_ready, 0);
      if (k == busy_at) in_valid = 1'b1;
      if (stall_len > 0 && k == stall_after + 1) begin
        ser_en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          in_valid = 1'b0;
          chk("stall_out", ser_out, d[8-k]);
          chk("stall_valid", ser_valid, 1);
          chk("stall_no_rem", rem_valid, 0);
        end
        ser_en = 1'b1;
      end
      tick();
      in_valid = 1'b0;
    end
    chk("rem_valid", rem_valid, 1);
    chk("rem_ser_valid_low", ser_valid, 0);
    r  = rem_out;
    dv = div5;
    tick();
    chk("rem_pulse_end", rem_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] r;
    logic       dv;
    logic       seen;
    int         accepts[$];

    vecs[0]  = '{8'h19, 3'd0, 1'b1, 0, 0, 0};
    vecs[1]  = '{8'h07, 3'd2, 1'b0, 0, 0, 0};
    vecs[2]  = '{8'h06, 3'd1, 1'b0, 0, 0, 0};
    vecs[3]  = '{8'hFE, 3'd4, 1'b0, 0, 0, 0};
    vecs[4]  = '{8'hFF, 3'd0, 1'b1, 0, 0, 0};
    vecs[5]  = '{8'h19, 3'd0, 1'b1, 4, 3, 0};
    vecs[6]  = '{8'h55, 3'd0, 1'b1, 0, 0, 3};
    vecs[7]  = '{8'h80, 3'd3, 1'b0, 0, 0, 0};
    vecs[8]  = '{8'hAB, 3'd1, 1'b0, 7, 2, 0};
    vecs[9]  = '{8'h3C, 3'd0, 1'b1, 0, 0, 1};
    vecs[10] = '{8'h01, 3'd1, 1'b0, 0, 1, 0};
    vecs[11] = '{8'h00, 3'd0, 1'b1, 0, 0, 8};
    vecs[12] = '{8'hC8, 3'd0, 1'b1, 2, 1, 0};

    reset = 1'b1; in_data = '0; in_valid = 1'b0; ser_en = 1'b0;
    in_data1 = '0; in_valid1 = 1'b0; ser_en1 = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_first", ser_first, 0);
    chk("rst_ser_last", ser_last, 0);
    chk("rst_rem_valid", rem_valid, 0);
    chk("rst_div5", div5, 0);
    chk("rst_rem_out", rem_out, 0);
    chk("rst_w1_in_ready", in_ready1, 1);
    chk("rst_w1_ser_valid", ser_valid1, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_frame(vecs[i].data, vecs[i].stall_after, vecs[i].stall_len, vecs[i].busy_at, r, dv);
      chk("vec_rem_out", r, vecs[i].rem);
      chk("vec_div5", dv, vecs[i].dv);
      chk("rem_hold_after_done", rem_out, vecs[i].rem);
    end

    for (int i = 0; i < 256; i++) begin
      run_frame(8'(i), 0, 0, 0, r, dv);
      chk("sweep_rem", r, 32'(i % 5));
      chk("sweep_div5", dv, (i % 5) == 0);
    end

    // Reset in the same cycle as an accept wins.
    in_data = 8'h13; in_valid = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_vs_accept_ready", in_ready, 1);
    chk("rst_vs_accept_valid", ser_valid, 0);

    // Reset during bit 5 aborts the frame.
    in_data = 8'h19; in_valid = 1'b1; ser_en = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("pre_rst_bit5", ser_out, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ser_valid", ser_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_rem_valid", rem_valid, 0);
    chk("midrst_rem_out", rem_out, 0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rem_valid) seen = 1'b1;
    end
    chk("midrst_no_rem_pulse", seen, 0);
    run_frame(8'h0A, 0, 0, 0, r, dv);
    chk("after_rst_rem", r, 0);
    chk("after_rst_div5", dv, 1);

    // Back-to-back with in_valid held high: accepts every W+2 = 10 cycles.
    in_data = 8'h33; in_valid = 1'b1; ser_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (in_ready) accepts.push_back(c);
      if (rem_valid) chk("b2b_rem", rem_out, 1);
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_accept_count", accepts.size() >= 3, 1);
    for (int j = 1; j < accepts.size(); j++)
      chk("b2b_spacing", 32'(accepts[j] - accepts[j-1]), 10);

    // W=1: single bit is both first and last.
    for (int j = 0; j < 2; j++) begin
      in_data1 = (j == 0) ? 1'b1 : 1'b0;
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      chk("w1_valid", ser_valid1, 1);
      chk("w1_first", ser_first1, 1);
      chk("w1_last", ser_last1, 1);
      chk("w1_out", ser_out1, (j == 0) ? 1 : 0);
      chk("w1_busy", in_ready1, 0);
      tick();
      chk("w1_rem_valid", rem_valid1, 1);
      chk("w1_rem_out", rem_out1, (j == 0) ? 1 : 0);
      chk("w1_div5", div5_1, (j == 0) ? 0 : 1);
      tick();
      chk("w1_ready_back", in_ready1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
